// File: rtl/mmio_uart_tx_responder.sv
// Memory-mapped UART 8N1 transmitter: CPU stores bytes to TXDATA, a FIFO buffers them,
// and a serialiser shifts each one out LSB first on tx.
module mmio_uart_tx_responder #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0400,
  parameter int          FIFO_DEPTH   = 16,
  parameter int          CLKS_PER_BIT = 4
) (
  input  logic        InputClk,
  input  logic        rst,
  input  logic [31:0] AddressBus,
  input  logic [31:0] DataBusOut,
  input  logic [2:0]  ControlBus,
  output logic [31:0] DataBusIn,
  output logic        Hit,
  output logic        tx,
  output logic        Busy
);

  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam int PTR_W  = ADDR_W + 1;
  localparam int CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CLK = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } txStateT;

  logic [7:0]       fifoMem [FIFO_DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W-1:0] fillCount;
  logic [7:0]       countByte;
  logic             fifoEmpty;
  logic             fifoFull;
  logic             ovf;
  logic             enable;

  logic [1:0]       regOffset;
  logic             wrStrobe;
  logic             rdStrobe;
  logic             pushReq;
  logic             pop;

  txStateT          state;
  txStateT          stateNext;
  logic [CNT_W-1:0] clkCnt;
  logic [CNT_W-1:0] clkCntNext;
  logic [2:0]       bitCnt;
  logic [2:0]       bitCntNext;
  logic [7:0]       shiftReg;
  logic [7:0]       shiftNext;
  logic             txBit;
  logic             bitDone;
  logic             unusedBits;

  assign Hit       = (AddressBus[31:4] == BASE_ADDR[31:4]);
  assign regOffset = AddressBus[3:2];
  assign wrStrobe  = Hit & ControlBus[2];
  assign rdStrobe  = Hit & ControlBus[1];
  assign pushReq   = wrStrobe && (regOffset == 2'd0);

  // The extra pointer bit distinguishes full from empty when the indices match.
  assign fillCount = wrPtr - rdPtr;
  assign countByte = 8'(fillCount);
  assign fifoEmpty = (wrPtr == rdPtr);
  assign fifoFull  = (wrPtr[ADDR_W] != rdPtr[ADDR_W]) &&
                     (wrPtr[ADDR_W-1:0] == rdPtr[ADDR_W-1:0]);

  assign unusedBits = ^{ControlBus[0], AddressBus[1:0], DataBusOut[31:8]};

  always_ff @(posedge InputClk) begin
    if (rst && pushReq && !fifoFull) begin
      fifoMem[wrPtr[ADDR_W-1:0]] <= DataBusOut[7:0];
    end
  end

  // A push against a full FIFO is dropped even when the serialiser pops on the same edge.
  always_ff @(posedge InputClk) begin
    if (!rst) begin
      wrPtr  <= '0;
      rdPtr  <= '0;
      ovf    <= 1'b0;
      enable <= 1'b1;
    end else begin
      if (pushReq) begin
        if (fifoFull) begin
          ovf <= 1'b1;
        end else begin
          wrPtr <= wrPtr + PTR_W'(1);
        end
      end else if (wrStrobe && (regOffset == 2'd1) && DataBusOut[3]) begin
        ovf <= 1'b0;
      end
      if (wrStrobe && (regOffset == 2'd2)) begin
        enable <= DataBusOut[0];
      end
      if (pop) begin
        rdPtr <= rdPtr + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge InputClk) begin
    if (!rst) begin
      state    <= IDLE;
      clkCnt   <= '0;
      bitCnt   <= '0;
      shiftReg <= '0;
    end else begin
      state    <= stateNext;
      clkCnt   <= clkCntNext;
      bitCnt   <= bitCntNext;
      shiftReg <= shiftNext;
    end
  end

  assign bitDone = (clkCnt == LAST_CLK);

  always_comb begin
    stateNext  = state;
    clkCntNext = clkCnt;
    bitCntNext = bitCnt;
    shiftNext  = shiftReg;
    pop        = 1'b0;
    txBit      = 1'b1;
    case (state)
      IDLE: begin
        if (enable && !fifoEmpty) begin
          pop        = 1'b1;
          shiftNext  = fifoMem[rdPtr[ADDR_W-1:0]];
          bitCntNext = 3'd0;
          clkCntNext = '0;
          stateNext  = START;
        end
      end
      START: begin
        txBit = 1'b0;
        if (bitDone) begin
          clkCntNext = '0;
          stateNext  = DATA;
        end else begin
          clkCntNext = clkCnt + CNT_W'(1);
        end
      end
      DATA: begin
        txBit = shiftReg[0];
        if (bitDone) begin
          clkCntNext = '0;
          shiftNext  = {1'b0, shiftReg[7:1]};
          bitCntNext = bitCnt + 3'd1;
          if (bitCnt == 3'd7) begin
            stateNext = STOP;
          end
        end else begin
          clkCntNext = clkCnt + CNT_W'(1);
        end
      end
      STOP: begin
        txBit = 1'b1;
        if (bitDone) begin
          clkCntNext = '0;
          stateNext  = IDLE;
        end else begin
          clkCntNext = clkCnt + CNT_W'(1);
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  assign tx   = txBit;
  assign Busy = (state != IDLE);

  // Read data is purely combinational so the single-cycle CPU sees it in the same cycle.
  always_comb begin
    DataBusIn = '0;
    if (rdStrobe) begin
      case (regOffset)
        2'd1:    DataBusIn = {16'b0, countByte, 4'b0, ovf, Busy, fifoEmpty, fifoFull};
        2'd2:    DataBusIn = {31'b0, enable};
        default: DataBusIn = '0;
      endcase
    end
  end

endmodule
